// File: rtl/frontend_ras_circ_if.sv
// Call/return decode side of the circular return-address stack.
// The ovf_cnt_o signal exists only when RAS_OVF_CNT_EN is defined.
interface frontend_ras_circ_if #(
  parameter int unsigned VLEN = 64
);
  logic            flush_i;
  logic            push_i;
  logic            pop_i;
  logic [VLEN-1:0] data_i;
  logic [VLEN-1:0] data_o;
  logic            valid_o;
  logic            full_o;
`ifdef RAS_OVF_CNT_EN
  logic [15:0]     ovf_cnt_o;
`endif

  modport master (
    output flush_i, push_i, pop_i, data_i,
    input  data_o, valid_o, full_o
`ifdef RAS_OVF_CNT_EN
    , ovf_cnt_o
`endif
  );

  modport slave (
    input  flush_i, push_i, pop_i, data_i,
    output data_o, valid_o, full_o
`ifdef RAS_OVF_CNT_EN
    , ovf_cnt_o
`endif
  );
endinterface

// File: rtl/frontend_ras_circ.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Optional saturating overflow counter enabled by defining RAS_OVF_CNT_EN.
module frontend_ras_circ #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned VLEN  = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  frontend_ras_circ_if.slave  ras
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t CntMax = cnt_t'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("frontend_ras_circ: DEPTH must be a power of two and >= 2");
  end

  logic [VLEN-1:0] mem_q [DEPTH];
  logic [VLEN-1:0] mem_d [DEPTH];
  ptr_t            tp_q, tp_d, tp_inc, tp_dec;
  cnt_t            cnt_q, cnt_d;
  logic            full;

  assign tp_inc = tp_q + ptr_t'(1);
  assign tp_dec = tp_q - ptr_t'(1);
  assign full   = (cnt_q == CntMax);

  always_comb begin
    mem_d = mem_q;
    tp_d  = tp_q;
    cnt_d = cnt_q;
    if (ras.flush_i) begin
      tp_d  = '0;
      cnt_d = '0;
    end else if (ras.push_i && ras.pop_i) begin
      // Empty stack: nothing to replace, so behave as a plain push.
      if (cnt_q == '0) begin
        mem_d[tp_inc] = ras.data_i;
        tp_d          = tp_inc;
        cnt_d         = cnt_t'(1);
      end else begin
        mem_d[tp_q] = ras.data_i;
      end
    end else if (ras.push_i) begin
      mem_d[tp_inc] = ras.data_i;
      tp_d          = tp_inc;
      if (!full) cnt_d = cnt_q + cnt_t'(1);
    end else if (ras.pop_i && cnt_q != '0) begin
      tp_d  = tp_dec;
      cnt_d = cnt_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
      tp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
    end
  end

  assign ras.data_o  = mem_q[tp_q];
  assign ras.valid_o = (cnt_q != '0);
  assign ras.full_o  = full;

`ifdef RAS_OVF_CNT_EN
  logic [15:0] ovf_q, ovf_d;

  // Counts push-only overwrites of the oldest entry; flush does not clear it.
  always_comb begin
    ovf_d = ovf_q;
    if (!ras.flush_i && ras.push_i && !ras.pop_i && full && ovf_q != 16'hFFFF) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ovf_q <= '0;
    else         ovf_q <= ovf_d;
  end

  assign ras.ovf_cnt_o = ovf_q;
`endif
endmodule

// File: tb/tb_frontend_ras_circ.sv
// Directed scoreboard bench for frontend_ras_circ (DEPTH = 2, VLEN = 64).
// Define RAS_OVF_CNT_EN for both files to also check the overflow counter.
module tb_frontend_ras_circ;
  localparam int unsigned Depth = 2;
  localparam int unsigned Vlen  = 64;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        flush;
    logic        push;
    logic        pop;
    logic [63:0] data;
    logic        exp_valid;
    logic        exp_full;
    logic [63:0] exp_data;
    logic        chk_data;
    logic [15:0] exp_ovf;
  } vec_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  frontend_ras_circ_if #(.VLEN(Vlen)) ras_if ();

  frontend_ras_circ #(
    .DEPTH(Depth),
    .VLEN (Vlen)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .ras   (ras_if)
  );

  always #5 clk_i = ~clk_i;

  vec_t vec_q[$];
  vec_t exp_q[$];
  int   vecs        = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic rst_n, input logic flush, input logic push,
                     input logic pop, input logic [63:0] data, input logic exp_valid,
                     input logic exp_full, input logic [63:0] exp_data, input logic chk_data,
                     input logic [15:0] exp_ovf);
    vec_t v;
    v.name = name; v.rst_n = rst_n; v.flush = flush; v.push = push; v.pop = pop;
    v.data = data; v.exp_valid = exp_valid; v.exp_full = exp_full;
    v.exp_data = exp_data; v.chk_data = chk_data; v.exp_ovf = exp_ovf;
    vec_q.push_back(v);
  endtask

  // Monitor: outputs are sampled 1 time unit after the edge that applied a vector.
  vec_t mon_e;
  always @(posedge clk_i) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check({mon_e.name, ".valid"}, 64'(ras_if.valid_o), 64'(mon_e.exp_valid));
      check({mon_e.name, ".full"},  64'(ras_if.full_o),  64'(mon_e.exp_full));
      if (mon_e.chk_data) check({mon_e.name, ".data"}, ras_if.data_o, mon_e.exp_data);
`ifdef RAS_OVF_CNT_EN
      check({mon_e.name, ".ovf"}, 64'(ras_if.ovf_cnt_o), 64'(mon_e.exp_ovf));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  localparam int PulseAt = 31;

  initial begin
    int wait_cycles;
    ras_if.flush_i = 1'b0;
    ras_if.push_i  = 1'b0;
    ras_if.pop_i   = 1'b0;
    ras_if.data_i  = '0;

    //   name       rst fl pu po data    v  f  exp_data  chk ovf
    add("t1_rst0",  0, 0, 0, 1, 64'h0,    0, 0, 64'h0,    1, 0);
    add("t1_rst1",  0, 0, 0, 1, 64'h0,    0, 0, 64'h0,    1, 0);
    add("t1_rst2",  0, 0, 0, 1, 64'h0,    0, 0, 64'h0,    1, 0);
    add("t1_idle",  1, 0, 0, 0, 64'h0,    0, 0, 64'h0,    1, 0);
    add("t2_push1", 1, 0, 1, 0, 64'h1000, 1, 0, 64'h1000, 1, 0);
    add("t2_push2", 1, 0, 1, 0, 64'h2000, 1, 1, 64'h2000, 1, 0);
    add("t2_pop1",  1, 0, 0, 1, 64'h0,    1, 0, 64'h1000, 1, 0);
    add("t2_pop2",  1, 0, 0, 1, 64'h0,    0, 0, 64'h0,    0, 0);
    add("t3_pushA", 1, 0, 1, 0, 64'hA0,   1, 0, 64'hA0,   1, 0);
    add("t3_pushB", 1, 0, 1, 0, 64'hB0,   1, 1, 64'hB0,   1, 0);
    add("t3_pushC", 1, 0, 1, 0, 64'hC0,   1, 1, 64'hC0,   1, 1);
    add("t3_pop1",  1, 0, 0, 1, 64'h0,    1, 0, 64'hB0,   1, 1);
    add("t3_pop2",  1, 0, 0, 1, 64'h0,    0, 0, 64'h0,    0, 1);
    add("t4_uf1",   1, 0, 0, 1, 64'h0,    0, 0, 64'h0,    0, 1);
    add("t4_uf2",   1, 0, 0, 1, 64'h0,    0, 0, 64'h0,    0, 1);
    add("t4_uf3",   1, 0, 0, 1, 64'h0,    0, 0, 64'h0,    0, 1);
    add("t4_push",  1, 0, 1, 0, 64'h40,   1, 0, 64'h40,   1, 1);
    add("t4_pop",   1, 0, 0, 1, 64'h0,    0, 0, 64'h0,    0, 1);
    add("t5_push",  1, 0, 1, 0, 64'h10,   1, 0, 64'h10,   1, 1);
    add("t5_pp",    1, 0, 1, 1, 64'h20,   1, 0, 64'h20,   1, 1);
    add("t5_pop",   1, 0, 0, 1, 64'h0,    0, 0, 64'h0,    0, 1);
    add("t5_ppemp", 1, 0, 1, 1, 64'h30,   1, 0, 64'h30,   1, 1);
    add("t6_push",  1, 0, 1, 0, 64'h50,   1, 1, 64'h50,   1, 1);
    add("t6_flpu",  1, 1, 1, 0, 64'h55,   0, 0, 64'h0,    0, 1);
    add("t6_push6", 1, 0, 1, 0, 64'h60,   1, 0, 64'h60,   1, 1);
    add("t6_push7", 1, 0, 1, 0, 64'h70,   1, 1, 64'h70,   1, 1);
    add("t6_push8", 1, 0, 1, 0, 64'h80,   1, 1, 64'h80,   1, 2);
    add("t6_ppful", 1, 0, 1, 1, 64'h90,   1, 1, 64'h90,   1, 2);
    add("t6_flpop", 1, 1, 0, 1, 64'h0,    0, 0, 64'h0,    0, 2);
    add("t6_idle",  1, 0, 0, 0, 64'h0,    0, 0, 64'h0,    0, 2);
    add("ar_push",  1, 0, 1, 0, 64'hAA,   1, 0, 64'hAA,   1, 2);
    // Async reset pulse lands before this entry; memory must read back as zero.
    add("ar_pushB", 1, 0, 1, 0, 64'hBB,   1, 0, 64'hBB,   1, 0);
    add("ar_pop",   1, 0, 0, 1, 64'h0,    0, 0, 64'h0,    0, 0);
    add("ar_pushC", 1, 0, 1, 0, 64'hCC,   1, 0, 64'hCC,   1, 0);
    add("ar_pop2",  1, 0, 0, 1, 64'h0,    0, 0, 64'h0,    0, 0);
    add("ar_zero",  1, 0, 1, 1, 64'hDD,   1, 0, 64'hDD,   1, 0);

    for (int i = 0; i < vec_q.size(); i++) begin
      @(negedge clk_i);
      if (i == PulseAt) begin
        #2 rst_ni = 1'b0;
        #1;
        check("ar_async.valid", 64'(ras_if.valid_o), 64'h0);
        check("ar_async.full",  64'(ras_if.full_o),  64'h0);
        check("ar_async.data",  ras_if.data_o,       64'h0);
`ifdef RAS_OVF_CNT_EN
        check("ar_async.ovf",   64'(ras_if.ovf_cnt_o), 64'h0);
`endif
        #1 rst_ni = 1'b1;
      end
      rst_ni         = vec_q[i].rst_n;
      ras_if.flush_i = vec_q[i].flush;
      ras_if.push_i  = vec_q[i].push;
      ras_if.pop_i   = vec_q[i].pop;
      ras_if.data_i  = vec_q[i].data;
      exp_q.push_back(vec_q[i]);
    end

    @(negedge clk_i);
    ras_if.flush_i = 1'b0;
    ras_if.push_i  = 1'b0;
    ras_if.pop_i   = 1'b0;
    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 10) begin
      @(negedge clk_i);
      wait_cycles++;
    end
    if (exp_q.size() != 0) begin
      vecs++;
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
